dac_array_ctrl: RTL

Parametrised multi-channel serial DAC controller, successor to the fixed per-channel mod_dac instances. It drives NCH DAC chips from one engine: shared scl, shared ldac and drst, and per-channel sync/sdo. Channels with pending updates are shifted in parallel in one frame, then committed together by a single ldac pulse. The block sits between the chdiv command generator (cmd*, clk domain c0) and the DAC pins.

---
 rtl/dac_array_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dac_array_ctrl.sv
// Multi-channel serial DAC controller: shifts pending channel frames out in parallel
// on a shared scl, then commits them together with a single ldac pulse.
module dac_array_ctrl #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned FRAME_W = 32,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LDAC_W  = 2,
  parameter int unsigned RST_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*FRAME_W-1:0] cmd,
  input  logic [NCH-1:0]         cmd_vld,
  output logic                   busy,
  output logic                   done,
  output logic [NCH-1:0]         sync,
  output logic                   scl,
  output logic [NCH-1:0]         sdo,
  output logic                   ldac,
  output logic                   drst
);

  localparam int unsigned MAX_A   = (CLK_DIV > LDAC_W) ? CLK_DIV : LDAC_W;
  localparam int unsigned CNT_MAX = (MAX_A > RST_W) ? MAX_A : RST_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_HOLD, S_LDAC
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIT_W-1:0]   bitn, bit_nxt;
  logic               start, shift_en, ldac_end;
  logic [NCH-1:0]     pend, sel;
  logic [FRAME_W-1:0] shadow [NCH];
  logic [FRAME_W-1:0] shreg  [NCH];
  logic               done_q;

  // State register and phase/bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      cnt   <= '0;
      bitn  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      bitn  <= bit_nxt;
    end
  end

  // Next-state logic; cnt counts cycles within the current phase
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    bit_nxt   = bitn;
    start     = 1'b0;
    shift_en  = 1'b0;
    ldac_end  = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == CNT_W'(RST_W - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        cnt_nxt = '0;
        if (|pend) begin
          start     = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = S_SHIFT_LO;
          cnt_nxt   = '0;
          bit_nxt   = BIT_W'(FRAME_W - 1);
        end
      end
      S_SHIFT_LO: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = S_SHIFT_HI;
          cnt_nxt   = '0;
        end
      end
      S_SHIFT_HI: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          cnt_nxt = '0;
          if (bitn == '0) begin
            state_nxt = S_HOLD;
          end else begin
            state_nxt = S_SHIFT_LO;
            bit_nxt   = bitn - BIT_W'(1);
            shift_en  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (cnt == CNT_W'(CLK_DIV - 1)) begin
          state_nxt = S_LDAC;
          cnt_nxt   = '0;
        end
      end
      S_LDAC: begin
        if (cnt == CNT_W'(LDAC_W - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          ldac_end  = 1'b1;
        end
      end
      default: begin
        state_nxt = S_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    busy = 1'b0;
    done = done_q;
    sync = '1;
    scl  = 1'b1;
    sdo  = '0;
    ldac = 1'b1;
    drst = (state != S_INIT);
    case (state)
      S_SETUP, S_SHIFT_LO, S_SHIFT_HI: begin
        busy = 1'b1;
        scl  = (state != S_SHIFT_LO);
        for (int i = 0; i < NCH; i++) begin
          sync[i] = ~sel[i];
          sdo[i]  = sel[i] & shreg[i][FRAME_W-1];
        end
      end
      S_HOLD: busy = 1'b1;
      S_LDAC: begin
        busy = 1'b1;
        ldac = 1'b0;
      end
      default: ;
    endcase
  end

  // Shadow/pending capture; strobes during a frame only affect the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      sel    <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
        shreg[i]  <= '0;
      end
    end else begin
      done_q <= ldac_end;
      if (start) begin
        sel  <= pend;
        pend <= cmd_vld;
      end else begin
        pend <= pend | cmd_vld;
      end
      for (int i = 0; i < NCH; i++) begin
        if (cmd_vld[i]) shadow[i] <= cmd[i*FRAME_W +: FRAME_W];
        if (start)         shreg[i] <= pend[i] ? shadow[i] : '0;
        else if (shift_en) shreg[i] <= shreg[i] << 1;
      end
    end
  end

endmodule
